// File: rtl/mem_lsu_pkg.sv
// Shared RV32I load/store encodings and the MEM-stage LSU state type.
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational store byte-enable/data formatting, load shift/extend and misalign check.
module lsu_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        mem_write_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mbe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned_o = addr_lo_i[0];
      2'b10:   misaligned_o = (addr_lo_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

  always_comb begin
    mbe_o   = 4'b1111;
    wdata_o = rs2_i;
    if (mem_write_i) begin
      case (store_funct3_t'(funct3_i))
        sb: begin
          mbe_o   = 4'b0001 << addr_lo_i;
          wdata_o = {4{rs2_i[7:0]}};
        end
        sh: begin
          mbe_o   = 4'b0011 << addr_lo_i;
          wdata_o = {2{rs2_i[15:0]}};
        end
        default: begin
          mbe_o   = 4'b1111;
          wdata_o = rs2_i;
        end
      endcase
    end
  end

  always_comb begin
    load_o = shifted;
    case (load_funct3_t'(funct3_i))
      lb:      load_o = {{24{shifted[7]}}, shifted[7:0]};
      lh:      load_o = {{16{shifted[15]}}, shifted[15:0]};
      lbu:     load_o = {24'b0, shifted[7:0]};
      lhu:     load_o = {16'b0, shifted[15:0]};
      default: load_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/response handshake, pipeline stall, load capture
// while the pipeline is frozen by another stall, and an optional wait watchdog.
module mem_lsu
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  input  logic        advance_i,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_resp,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        timeout_o
);

  lsu_state_t  state_q, state_d;
  logic [31:0] cap_q, load_fmt, load_val;
  logic [15:0] cnt_q;
  logic [16:0] cnt_inc;
  logic        access, mis, req, cap_en;

  lsu_align u_align (
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .mem_write_i  (mem_write_i),
    .rs2_i        (rs2_i),
    .rdata_i      (data_rdata),
    .mbe_o        (data_mbe),
    .wdata_o      (data_wdata),
    .load_o       (load_fmt),
    .misaligned_o (mis)
  );

  assign access       = mem_read_i | mem_write_i;
  assign misaligned_o = access & mis;
  assign req          = access & ~mis;
  assign data_addr    = {addr_i[31:2], 2'b00};
  assign load_val     = mem_read_i ? load_fmt : 32'b0;
  assign cnt_inc      = {1'b0, cnt_q} + 17'd1;

  always_comb begin
    state_d    = state_q;
    data_read  = 1'b0;
    data_write = 1'b0;
    stall_o    = 1'b0;
    rdata_o    = 32'b0;
    cap_en     = 1'b0;
    case (state_q)
      IDLE, ACCESS: begin
        if (req) begin
          data_read  = mem_read_i;
          data_write = mem_write_i;
          if (!data_resp) begin
            stall_o = 1'b1;
            state_d = ACCESS;
          end else begin
            rdata_o = load_val;
            if (advance_i) begin
              state_d = IDLE;
            end else begin
              state_d = HOLD;
              cap_en  = 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        rdata_o = cap_q;
        if (advance_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must kill an in-flight request in the same cycle, not one edge later.
    if (rst) begin
      state_d    = IDLE;
      data_read  = 1'b0;
      data_write = 1'b0;
      stall_o    = 1'b0;
      rdata_o    = 32'b0;
      cap_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cap_q     <= 32'b0;
      cnt_q     <= 16'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_en) cap_q <= load_val;
      if (state_q == ACCESS && state_d == ACCESS) begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_inc[15:0];
        if (TIMEOUT_CYCLES > 0 && {15'b0, cnt_inc} >= TIMEOUT_CYCLES) timeout_o <= 1'b1;
      end else begin
        cnt_q <= 16'b0;
      end
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit of the MEM stage. Sits between the EX/MEM register and mem_wb_reg.
- Issues data-memory requests and formats store byte-enables and write data.
- Runs a request/response handshake with the data memory and stalls the pipeline until the memory responds.
- Aligns and sign/zero-extends load data, which drives mem_wb_reg's data_rdata_i.

Parameters:
- TIMEOUT_CYCLES, 0, watchdog limit on cycles spent waiting in ACCESS. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read_i  in  1  current MEM instruction is a load
- mem_write_i  in  1  current MEM instruction is a store
- funct3_i  in  3  load/store width and sign (RV32I encoding)
- addr_i  in  32  effective address (ALU result)
- rs2_i  in  32  store source data
- advance_i  in  1  global pipeline load enable (stage registers advance this cycle)
- data_read  out  1  memory read request
- data_write  out  1  memory write request
- data_mbe  out  4  byte enables
- data_addr  out  32  word-aligned address, {addr_i[31:2],2'b00}
- data_wdata  out  32  replicated store data
- data_rdata  in  32  memory read data
- data_resp  in  1  memory response, one cycle per access
- rdata_o  out  32  aligned and extended load value
- stall_o  out  1  hold the pipeline (drops advance_i upstream)
- misaligned_o  out  1  current access is misaligned
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: state IDLE, captured-data register 0, wait counter 0, timeout_o 0.
  - Output values in reset follow from IDLE with no request: data_read=data_write=0, stall_o=0, rdata_o=0.
- req = (mem_read_i | mem_write_i) & ~misaligned_o.
- Misalignment:
  - Halfword access (funct3[1:0]=01) with addr_i[0]=1, or word access (10) with addr_i[1:0]≠0, sets misaligned_o combinationally.
  - A misaligned access issues no request, drives stall_o=0 and rdata_o=0.
- Store formatting:
  - SB: mbe = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: mbe = 4'b0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: mbe = 4'b1111, wdata = rs2.
- Loads:
  - data_mbe = 4'b1111.
  - Shift data_rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Requests are combinational from the inputs in IDLE and ACCESS and are held until data_resp.
- FSM IDLE: drives data_read/data_write = mem_read_i/mem_write_i gated by req.
  - req & ~data_resp → ACCESS, stall_o=1.
  - req & data_resp & advance_i → IDLE; zero-wait access, stall_o=0, rdata_o from data_rdata this cycle.
  - req & data_resp & ~advance_i → HOLD; capture the formatted load data.
- FSM ACCESS: requests held; stall_o = ~data_resp; wait counter increments each cycle.
  - data_resp & advance_i → IDLE.
  - data_resp & ~advance_i → HOLD; capture data.
  - Wait counter clears on leaving ACCESS.
- FSM HOLD: entered when another stall freezes the pipeline after completion.
  - No requests are issued, which prevents re-issuing the access.
  - stall_o=0; rdata_o = captured register.
  - advance_i → IDLE.
- rdata_o source: combinational formatted data_rdata in IDLE/ACCESS on the data_resp cycle; captured register in HOLD; 0 otherwise.
- A data_resp in IDLE without req is ignored (stray response after reset).
- Watchdog:
  - When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, timeout_o is set.
  - timeout_o stays set until rst.
  - The counter saturates at 16 bits.
- Reset mid-access drops requests the same cycle and returns to IDLE.

Decomposition:
- rv32i_types package: load_funct3_t (lb,lh,lw,lbu,lhu), store_funct3_t (sb,sh,sw), lsu_state_t (IDLE, ACCESS, HOLD).
- Sub-module lsu_align: purely combinational store mbe/wdata generation, load shift/extend, and misalign check.
- mem_lsu holds the FSM, the capture register and the watchdog.

Test Plan:
- LW addr 0x100, data_resp asserted 2 cycles after request, data_rdata 0xDEADBEEF, advance_i=1 → stall_o high 2 cycles, rdata_o=0xDEADBEEF on resp cycle, data_read drops next cycle.
- LB addr 0x103, rdata 0x80FF_0000, zero wait → rdata_o=0xFFFFFF80; same with LBU → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, rs2 0x12345678 → data_mbe=4'b0010, data_wdata=0x78787878, data_addr=0x200; SH addr 0x202 → mbe 4'b1100, wdata 0x56785678.
- LH addr 0x101 → misaligned_o=1, data_read=0, stall_o=0, rdata_o=0.
- LW resp arrives with advance_i=0 for 3 cycles → state HOLD, single request only, rdata_o held at captured value until advance_i=1.
- TIMEOUT_CYCLES=4, data_resp never asserted → timeout_o=1 after 4 ACCESS cycles; rst mid-access → requests drop, timeout_o clears.
